// File: rtl/text_char_gen.sv
// Text-mode character generator: raster position -> text RAM -> font ROM -> serial pixel.
// Fixed 4-clock latency; the blinking block cursor exists only with `define TEXT_CURSOR_EN.
module text_char_gen #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clka,
  input  logic        rsta_n,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic        pix_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  // Sideband that travels with each pixel from stage 0 to stage 1.
  typedef struct packed {
    logic [2:0] sub;
    logic [3:0] cl;
    logic       de;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       cur;
  } tag_t;

  localparam logic [7:0] COLS_L = 8'(COLS);
  localparam logic [5:0] ROWS_L = 6'(ROWS);

  // ---------------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------------
  logic [9:0] px_q, px_d;
  logic [8:0] ly_q, ly_d;
  logic       de_prev_q;
  logic       de_fall;
  logic [6:0] col;
  logic [4:0] row;
  logic [3:0] cl;

  assign de_fall = de_prev_q & ~de_in;
  assign col     = px_q[9:3];
  assign row     = ly_q[8:4];
  assign cl      = ly_q[3:0];

  always_comb begin
    px_d = px_q;
    ly_d = ly_q;
    if (de_fall) begin
      px_d = '0;
      if (ly_q != '1) ly_d = ly_q + 9'd1;
    end else if (de_in && (px_q != '1)) begin
      px_d = px_q + 10'd1;
    end
    // Frame sync has priority over the end-of-line increment.
    if (vs_in) ly_d = '0;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      px_q      <= '0;
      ly_q      <= '0;
      de_prev_q <= 1'b0;
    end else begin
      px_q      <= px_d;
      ly_q      <= ly_d;
      de_prev_q <= de_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Cursor hit, evaluated at stage 0 and carried as a tag
  // ---------------------------------------------------------------------------
  logic cur_hit;

`ifdef TEXT_CURSOR_EN
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       vs_prev_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_in && !vs_prev_q) frame_cnt_d = frame_cnt_q + 6'd1;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      frame_cnt_q <= '0;
      vs_prev_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      vs_prev_q   <= vs_in;
    end
  end

  // Underline-style block on the bottom two cell lines, visible in the first half of the blink period.
  assign cur_hit = (col == cursor_col) && (row == cursor_row) &&
                   (cl[3:1] == 3'b111) && !frame_cnt_q[5];
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
  assign cur_hit       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 0: text RAM address and tags
  // ---------------------------------------------------------------------------
  logic [11:0] vram_addr_q, vram_addr_d;
  tag_t        t0_q, t0_d;
  tag_t        t1_q;

  always_comb begin
    vram_addr_d = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    t0_d        = '0;
    t0_d.sub    = px_q[2:0];
    t0_d.cl     = cl;
    t0_d.de     = de_in;
    t0_d.vis    = ({1'b0, col} < COLS_L) && ({1'b0, row} < ROWS_L);
    t0_d.hs     = hs_in;
    t0_d.vs     = vs_in;
    t0_d.cur    = cur_hit;
  end

  // ---------------------------------------------------------------------------
  // Stages 1..3: character capture, font address, pixel select
  // ---------------------------------------------------------------------------
  logic [7:0]  chr_q;
  logic [10:0] font_addr_q;
  logic        inv_q;
  logic [2:0]  sub2_q;
  logic        de2_q, vis2_q, hs2_q, vs2_q, cur2_q;
  logic        pix_q, pix_d;
  logic        de_out_q, hs_out_q, vs_out_q;

  always_comb begin
    pix_d = 1'b0;
    // Blanked pixels stay 0: neither inverse video nor the cursor applies to them.
    if (de2_q && vis2_q) pix_d = font_data[3'd7 - sub2_q] ^ inv_q ^ cur2_q;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      vram_addr_q <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      chr_q       <= '0;
      font_addr_q <= '0;
      inv_q       <= 1'b0;
      sub2_q      <= '0;
      de2_q       <= 1'b0;
      vis2_q      <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      cur2_q      <= 1'b0;
      pix_q       <= 1'b0;
      de_out_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
    end else begin
      vram_addr_q <= vram_addr_d;
      t0_q        <= t0_d;
      chr_q       <= vram_data;
      t1_q        <= t0_q;
      font_addr_q <= {chr_q[6:0], t1_q.cl};
      inv_q       <= chr_q[7];
      sub2_q      <= t1_q.sub;
      de2_q       <= t1_q.de;
      vis2_q      <= t1_q.vis;
      hs2_q       <= t1_q.hs;
      vs2_q       <= t1_q.vs;
      cur2_q      <= t1_q.cur;
      pix_q       <= pix_d;
      de_out_q    <= de2_q;
      hs_out_q    <= hs2_q;
      vs_out_q    <= vs2_q;
    end
  end

  assign vram_addr = vram_addr_q;
  assign font_addr = font_addr_q;
  assign pix_out   = pix_q;
  assign de_out    = de_out_q;
  assign hs_out    = hs_out_q;
  assign vs_out    = vs_out_q;

endmodule

// File: tb/tb_text_char_gen.sv
// Directed bench for text_char_gen: cell table plus reset, blanking, frame-wrap and cursor sequences.
// Behavioural text RAM and font ROM answer combinationally from the registered addresses.
module tb_text_char_gen;

  localparam int HMAX = 65536;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        de_in, hs_in, vs_in;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        pix_out, de_out, hs_out, vs_out;

  logic [7:0]  vram_mem [0:4095];
  logic [7:0]  rom_mem  [0:2047];

  always #5 clka = ~clka;

  assign vram_data = vram_mem[vram_addr];
  assign font_data = rom_mem[font_addr];

  text_char_gen dut (
    .clka       (clka),
    .rsta_n     (rsta_n),
    .de_in      (de_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pix_out    (pix_out),
    .de_out     (de_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  // History: entry k holds the outputs seen just before input k is driven.
  // Input k therefore shows up on vram_addr at k+1, font_addr at k+3, pix/de/hs/vs_out at k+4.
  int          cyc, n_tests, n_fail, mark;
  logic        h_pix [HMAX];
  logic        h_de  [HMAX];
  logic        h_hs  [HMAX];
  logic        h_vs  [HMAX];
  logic        i_de  [HMAX];
  logic        i_hs  [HMAX];
  logic        i_vs  [HMAX];
  logic [11:0] h_va  [HMAX];
  logic [10:0] h_fa  [HMAX];

  typedef struct {
    int         row;
    int         col;
    int         cl;
    logic [7:0] chr;
    logic [7:0] glyph;
    logic [11:0] va;
    logic [10:0] fa;
    logic [7:0] pix;
  } vec_t;

  vec_t vecs [7];

`ifdef TEXT_CURSOR_EN
  localparam logic [7:0] CUR_ON = 8'hFF;
`else
  localparam logic [7:0] CUR_ON = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs);
    @(negedge clka);
    if (cyc < HMAX) begin
      h_pix[cyc] = pix_out;
      h_de[cyc]  = de_out;
      h_hs[cyc]  = hs_out;
      h_vs[cyc]  = vs_out;
      h_va[cyc]  = vram_addr;
      h_fa[cyc]  = font_addr;
      i_de[cyc]  = de;
      i_hs[cyc]  = hs;
      i_vs[cyc]  = vs;
    end
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    cyc++;
  endtask

  task automatic new_frame();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_line(input int len, output int s);
    s = cyc;
    repeat (len) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] cell_bits(input int s, input int c);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[7-b] = h_pix[s + 8*c + b + 4];
    return r;
  endfunction

  initial begin
    vec_t v;
    int   s, s77, s78, s79, first, line, addr;
    int   err, err_de, err_hs, err_vs;

    cyc = 0; n_tests = 0; n_fail = 0; mark = 0;
    rsta_n = 1'b0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    cursor_col = 7'd10;
    cursor_row = 5'd4;
    for (int i = 0; i < 4096; i++) vram_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'h00;

    // row, col, cl, char, glyph row, vram_addr, font_addr, pixel byte
    vecs[0] = '{0,  0, 0,  8'h01, 8'h3C, 12'h000, 11'h010, 8'h3C};
    vecs[1] = '{0,  1, 5,  8'hC1, 8'h3C, 12'h001, 11'h415, 8'hC3};
    vecs[2] = '{2,  5, 3,  8'h41, 8'h81, 12'h0A5, 11'h413, 8'h81};
    vecs[3] = '{1,  3, 15, 8'h7F, 8'hF0, 12'h053, 11'h7FF, 8'hF0};
    vecs[4] = '{0,  2, 7,  8'h80, 8'h00, 12'h002, 11'h007, 8'hFF};
    vecs[5] = '{29, 0, 15, 8'h12, 8'hA5, 12'h910, 11'h12F, 8'hA5};
    vecs[6] = '{30, 0, 0,  8'h12, 8'hFF, 12'h960, 11'h120, 8'h00};

    // Reset held with live stimulus; an inverse cell would light pix_out if the pipe ran.
    vram_mem[0] = 8'h80;
    repeat (6) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("rst_pix", pix_out, 1'b0);
    check("rst_de", de_out, 1'b0);
    check("rst_hs", hs_out, 1'b0);
    check("rst_vs", vs_out, 1'b0);
    check("rst_vram_addr", vram_addr, 12'h000);
    check("rst_font_addr", font_addr, 11'h000);

    rsta_n = 1'b1;
    mark = cyc;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_line(16, s);
    first = -1;
    for (int j = mark; j < cyc; j++) if (first < 0 && h_de[j] === 1'b1) first = j;
    check("first_de_out_latency", first, s + 4);
    check("first_pix_valid", h_pix[s+4], 1'b1);
    check("pix_before_first", h_pix[s+3], 1'b0);

    // Mid-line asynchronous reset on row 1, then restart from px=0, ly=0.
    repeat (15) run_line(16, s);
    vram_mem[80] = 8'h80;
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("midline_pix_pre", pix_out, 1'b1);
    #2 rsta_n = 1'b0;
    #1;
    check("midline_async_pix", pix_out, 1'b0);
    check("midline_async_de", de_out, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rsta_n = 1'b1;
    mark = cyc;
    step(1'b0, 1'b0, 1'b0);
    run_line(24, s);
    check("restart_vram_addr_col0", h_va[s+1], 12'h000);
    check("restart_vram_addr_col1", h_va[s+9], 12'h001);
    vram_mem[0]  = 8'h00;
    vram_mem[80] = 8'h00;

    // Cell table.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      addr = v.row * 80 + v.col;
      vram_mem[addr] = v.chr;
      rom_mem[{v.chr[6:0], v.cl[3:0]}] = v.glyph;
      line = v.row * 16 + v.cl;
      new_frame();
      for (int l = 0; l <= line; l++) run_line(8 * (v.col + 2), s);
      check($sformatf("vec%0d_pix", i), cell_bits(s, v.col), v.pix);
      check($sformatf("vec%0d_vram_addr", i), h_va[s + 8*v.col + 1], v.va);
      check($sformatf("vec%0d_font_addr", i), h_fa[s + 8*v.col + 3], v.fa);
      vram_mem[addr] = 8'h00;
      rom_mem[{v.chr[6:0], v.cl[3:0]}] = 8'h00;
    end

    // Overlong line: column 79 visible, column 80+ blanked, px saturates at 1023.
    vram_mem[0]   = 8'h80;
    vram_mem[79]  = 8'h80;
    vram_mem[80]  = 8'h80;
    vram_mem[127] = 8'h80;
    first = cyc;
    new_frame();
    run_line(1100, s);
    check("col79_visible", cell_bits(s, 79), 8'hFF);
    check("col80_blank", cell_bits(s, 80), 8'h00);
    check("px_saturate_vram_addr", h_va[s+1100], 12'd127);
    err = 0;
    for (int j = s + 644; j < s + 1104; j++) if (h_pix[j] !== 1'b0) err++;
    check("past_col79_pix_zero", err, 0);
    err = 0;
    for (int j = first; j < cyc; j++) if (h_de[j] === 1'b0 && h_pix[j] !== 1'b0) err++;
    check("inverse_blanked_outside_de", err, 0);
    vram_mem[0]   = 8'h00;
    vram_mem[79]  = 8'h00;
    vram_mem[80]  = 8'h00;
    vram_mem[127] = 8'h00;

    // vs coincident with the de falling edge: next line is row 0, cell line 0.
    new_frame();
    repeat (20) run_line(16, s);
    repeat (16) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    run_line(16, s);
    check("wrap_vram_addr", h_va[s+1], 12'h000);
    check("wrap_font_addr", h_fa[s+3], 11'h000);

    // Sync outputs are the inputs shifted by four clocks since the last reset.
    err_de = 0; err_hs = 0; err_vs = 0;
    for (int j = mark + 4; j < cyc; j++) begin
      if (h_de[j] !== i_de[j-4]) err_de++;
      if (h_hs[j] !== i_hs[j-4]) err_hs++;
      if (h_vs[j] !== i_vs[j-4]) err_vs++;
    end
    check("de_out_delay4", err_de, 0);
    check("hs_out_delay4", err_hs, 0);
    check("vs_out_delay4", err_vs, 0);

    // Cursor at (10,4), blank glyph; fresh reset so the frame counter starts at 0.
    rsta_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rsta_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    new_frame();
    s77 = 0; s78 = 0; s79 = 0;
    for (int l = 0; l < 80; l++) begin
      run_line(96, s);
      if (l == 77) s77 = s;
      if (l == 78) s78 = s;
      if (l == 79) s79 = s;
    end
    check("cursor_line77", cell_bits(s77, 10), 8'h00);
    check("cursor_line78", cell_bits(s78, 10), CUR_ON);
    check("cursor_line79", cell_bits(s79, 10), CUR_ON);
    check("cursor_neighbour_col", cell_bits(s79, 9), 8'h00);
`ifdef TEXT_CURSOR_EN
    repeat (30) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    new_frame();
    for (int l = 0; l < 80; l++) begin
      run_line(96, s);
      if (l == 78) s78 = s;
      if (l == 79) s79 = s;
    end
    check("cursor_off_line78", cell_bits(s78, 10), 8'h00);
    check("cursor_off_line79", cell_bits(s79, 10), 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
